// File: rtl/bsg_halfpod_reset_seq_pkg.sv
// Shared types and defaults for the halfpod reset sequencer.
package bsg_halfpod_reset_seq_pkg;

    localparam int unsigned hold_cycles_default_gp = 64;
    localparam int unsigned step_cycles_default_gp = 16;

    typedef enum logic [2:0] {
        e_idle,
        e_hold,
        e_up_rel,
        e_dn_rel,
        e_tok_rel,
        e_ds_rel,
        e_core_rel,
        e_done
    } bsg_halfpod_reset_seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_halfpod_step_timer.sv
// Loadable down-counter that saturates at zero; expired flags a zero count.
module bsg_halfpod_step_timer #(
    parameter int unsigned width_p = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [width_p-1:0] load_value,
    output logic               expired
);

    logic [width_p-1:0] count_r;

    // Load on strobe, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != '0) begin
            count_r <= count_r - width_p'(1);
        end
    end

    assign expired = (count_r == '0);

endmodule

// File: rtl/bsg_halfpod_reset_sequencer.sv
// Timed bring-up of a halfpod's SDR link resets and core reset from a single
// start pulse, with Y coordinate capture.
// Optional feature: define BSG_HALFPOD_RESET_SEQ_SDR_DISABLE_EN to drive a
// registered sdr_disable_o; otherwise sdr_disable_o is tied low.
module bsg_halfpod_reset_sequencer
    import bsg_halfpod_reset_seq_pkg::*;
#(
    parameter int unsigned step_cycles_p  = step_cycles_default_gp,
    parameter int unsigned hold_cycles_p  = hold_cycles_default_gp,
    parameter int unsigned y_cord_width_p = 7
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [y_cord_width_p-1:0] y_cord_i,
    output logic                      uplink_reset_o,
    output logic                      downlink_reset_o,
    output logic                      token_reset_o,
    output logic                      downstream_reset_o,
    output logic                      core_reset_o,
    output logic [y_cord_width_p-1:0] y_cord_o,
    output logic                      sdr_disable_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned timer_width_lp = $clog2(max_u(hold_cycles_p, step_cycles_p) + 1);

    // Timer holds the remaining cycles after the current one, so a state of
    // N cycles loads N-1 and advances on the cycle its count reads zero.
    localparam logic [timer_width_lp-1:0] hold_load_lp = timer_width_lp'(hold_cycles_p - 1);
    localparam logic [timer_width_lp-1:0] step_load_lp = timer_width_lp'(step_cycles_p - 1);

    bsg_halfpod_reset_seq_state_e state_r, state_n;

    logic                      timer_load;
    logic [timer_width_lp-1:0] timer_value;
    logic                      timer_expired;

    bsg_halfpod_step_timer #(
        .width_p(timer_width_lp)
    ) step_timer (
        .clk       (clk_i),
        .reset     (reset_i),
        .load      (timer_load),
        .load_value(timer_value),
        .expired   (timer_expired)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state and timer loads; a start from any state restarts into HOLD.
    always_comb begin
        state_n     = state_r;
        timer_load  = 1'b0;
        timer_value = hold_load_lp;
        if (start_i) begin
            state_n     = e_hold;
            timer_load  = 1'b1;
            timer_value = hold_load_lp;
        end else begin
            unique case (state_r)
                e_idle: state_n = e_idle;
                e_hold: if (timer_expired) begin
                    state_n     = e_up_rel;
                    timer_load  = 1'b1;
                    timer_value = step_load_lp;
                end
                e_up_rel: if (timer_expired) begin
                    state_n     = e_dn_rel;
                    timer_load  = 1'b1;
                    timer_value = step_load_lp;
                end
                e_dn_rel: if (timer_expired) begin
                    state_n     = e_tok_rel;
                    timer_load  = 1'b1;
                    timer_value = step_load_lp;
                end
                e_tok_rel: if (timer_expired) begin
                    state_n     = e_ds_rel;
                    timer_load  = 1'b1;
                    timer_value = step_load_lp;
                end
                e_ds_rel: if (timer_expired) begin
                    state_n     = e_core_rel;
                    timer_load  = 1'b1;
                    timer_value = step_load_lp;
                end
                e_core_rel: if (timer_expired) begin
                    state_n = e_done;
                end
                e_done: state_n = e_done;
                default: state_n = e_idle;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register, with no input-to-output path.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            uplink_reset_o     <= 1'b1;
            downlink_reset_o   <= 1'b1;
            token_reset_o      <= 1'b1;
            downstream_reset_o <= 1'b1;
            core_reset_o       <= 1'b1;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            y_cord_o           <= '0;
        end else begin
            uplink_reset_o     <= (state_n inside {e_idle, e_hold});
            downlink_reset_o   <= (state_n inside {e_idle, e_hold, e_up_rel});
            token_reset_o      <= (state_n inside {e_idle, e_hold, e_up_rel, e_dn_rel});
            downstream_reset_o <= (state_n inside {e_idle, e_hold, e_up_rel, e_dn_rel, e_tok_rel});
            core_reset_o       <= (state_n inside {e_idle, e_hold, e_up_rel, e_dn_rel, e_tok_rel, e_ds_rel});
            busy_o             <= (state_n inside {e_hold, e_up_rel, e_dn_rel, e_tok_rel, e_ds_rel, e_core_rel});
            done_o             <= (state_n == e_done);
            if (start_i) begin
                y_cord_o <= y_cord_i;
            end
        end
    end

`ifdef BSG_HALFPOD_RESET_SEQ_SDR_DISABLE_EN
    logic sdr_disable_r;

    // SDR stays disabled until the downstream reset is released.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sdr_disable_r <= 1'b1;
        end else begin
            sdr_disable_r <= !(state_n inside {e_ds_rel, e_core_rel, e_done});
        end
    end

    assign sdr_disable_o = sdr_disable_r;
`else
    assign sdr_disable_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_halfpod_reset_sequencer.sv
// Directed bench for bsg_halfpod_reset_sequencer: default timing, restart,
// mid-sequence reset, restart/expiry collision and minimum 1/1 timing.
module tb_bsg_halfpod_reset_sequencer;

`ifdef BSG_HALFPOD_RESET_SEQ_SDR_DISABLE_EN
    localparam logic sdr_on = 1'b1;
`else
    localparam logic sdr_on = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: default parameters
    logic       a_reset, a_start;
    logic [6:0] a_y_in, a_y;
    logic       a_up, a_dn, a_tok, a_ds, a_core, a_sdr, a_busy, a_done;

    // Instance b: hold=1, step=1
    logic       b_reset, b_start;
    logic [6:0] b_y_in, b_y;
    logic       b_up, b_dn, b_tok, b_ds, b_core, b_sdr, b_busy, b_done;

    bsg_halfpod_reset_sequencer dut_a (
        .clk_i             (clk),
        .reset_i           (a_reset),
        .start_i           (a_start),
        .y_cord_i          (a_y_in),
        .uplink_reset_o    (a_up),
        .downlink_reset_o  (a_dn),
        .token_reset_o     (a_tok),
        .downstream_reset_o(a_ds),
        .core_reset_o      (a_core),
        .y_cord_o          (a_y),
        .sdr_disable_o     (a_sdr),
        .busy_o            (a_busy),
        .done_o            (a_done)
    );

    bsg_halfpod_reset_sequencer #(
        .step_cycles_p (1),
        .hold_cycles_p (1),
        .y_cord_width_p(7)
    ) dut_b (
        .clk_i             (clk),
        .reset_i           (b_reset),
        .start_i           (b_start),
        .y_cord_i          (b_y_in),
        .uplink_reset_o    (b_up),
        .downlink_reset_o  (b_dn),
        .token_reset_o     (b_tok),
        .downstream_reset_o(b_ds),
        .core_reset_o      (b_core),
        .y_cord_o          (b_y),
        .sdr_disable_o     (b_sdr),
        .busy_o            (b_busy),
        .done_o            (b_done)
    );

    int unsigned cyc;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [4:0] a_rv();
        return {a_core, a_ds, a_tok, a_dn, a_up};
    endfunction

    function automatic logic [4:0] b_rv();
        return {b_core, b_ds, b_tok, b_dn, b_up};
    endfunction

    task automatic reset_a();
        a_reset = 1'b1;
        a_start = 1'b0;
        tick();
        tick();
        a_reset = 1'b0;
        cyc     = 0;
    endtask

    initial begin
        a_reset = 1'b1; a_start = 1'b0; a_y_in = '0;
        b_reset = 1'b1; b_start = 1'b0; b_y_in = '0;
        cyc = 0;

        // Run 1: full sequence, then restart from DONE
        reset_a();
        while (cyc < 175) begin
            a_start = (cyc == 10) || (cyc == 170);
            a_y_in  = (cyc == 170) ? 7'd2 : 7'd5;
            tick();
            case (cyc)
                5: begin
                    check("rst_rv", a_rv(), 5'b11111);
                    check("rst_busy", a_busy, 0);
                    check("rst_done", a_done, 0);
                    check("rst_y", a_y, 0);
                    check("rst_sdr", a_sdr, sdr_on);
                end
                11: begin
                    check("start_busy", a_busy, 1);
                    check("start_y", a_y, 5);
                    check("start_rv", a_rv(), 5'b11111);
                end
                74:  check("pre_up", a_rv(), 5'b11111);
                75:  check("up_rel", a_rv(), 5'b11110);
                90:  check("pre_dn", a_rv(), 5'b11110);
                91:  check("dn_rel", a_rv(), 5'b11100);
                106: check("pre_tok", a_rv(), 5'b11100);
                107: check("tok_rel", a_rv(), 5'b11000);
                122: begin
                    check("pre_ds", a_rv(), 5'b11000);
                    check("sdr_122", a_sdr, sdr_on);
                end
                123: begin
                    check("ds_rel", a_rv(), 5'b10000);
                    check("sdr_123", a_sdr, 0);
                end
                138: check("pre_core", a_rv(), 5'b10000);
                139: begin
                    check("core_rel", a_rv(), 5'b00000);
                    check("core_busy", a_busy, 1);
                end
                154: begin
                    check("pre_done", a_done, 0);
                    check("pre_done_busy", a_busy, 1);
                end
                155: begin
                    check("done", a_done, 1);
                    check("done_busy", a_busy, 0);
                    check("done_rv", a_rv(), 5'b00000);
                end
                165: check("done_hold", a_done, 1);
                171: begin
                    check("rs_done_rv", a_rv(), 5'b11111);
                    check("rs_done_done", a_done, 0);
                    check("rs_done_busy", a_busy, 1);
                    check("rs_done_y", a_y, 2);
                    check("rs_done_sdr", a_sdr, sdr_on);
                end
                default: ;
            endcase
        end

        // Run 2: restart in DN_REL
        reset_a();
        while (cyc < 170) begin
            a_start = (cyc == 10) || (cyc == 100);
            a_y_in  = (cyc == 100) ? 7'd9 : 7'd5;
            tick();
            case (cyc)
                99:  check("r2_dn_state", a_rv(), 5'b11100);
                101: begin
                    check("r2_rv", a_rv(), 5'b11111);
                    check("r2_y", a_y, 9);
                    check("r2_busy", a_busy, 1);
                end
                164: check("r2_pre_up", a_rv(), 5'b11111);
                165: check("r2_up", a_rv(), 5'b11110);
                default: ;
            endcase
        end

        // Run 3: reset in DS_REL
        reset_a();
        while (cyc < 201) begin
            a_start = (cyc == 10);
            a_y_in  = 7'd5;
            a_reset = (cyc == 130);
            tick();
            case (cyc)
                130: check("r3_ds", a_rv(), 5'b10000);
                131: begin
                    check("r3_rv", a_rv(), 5'b11111);
                    check("r3_busy", a_busy, 0);
                    check("r3_done", a_done, 0);
                    check("r3_y", a_y, 0);
                    check("r3_sdr", a_sdr, sdr_on);
                end
                200: begin
                    check("r3_idle_rv", a_rv(), 5'b11111);
                    check("r3_idle_busy", a_busy, 0);
                end
                default: ;
            endcase
        end
        a_reset = 1'b0;

        // Run 4: restart on the cycle the HOLD timer expires
        reset_a();
        while (cyc < 141) begin
            a_start = (cyc == 10) || (cyc == 74);
            a_y_in  = (cyc == 74) ? 7'd3 : 7'd5;
            tick();
            case (cyc)
                75: begin
                    check("r4_rv", a_rv(), 5'b11111);
                    check("r4_busy", a_busy, 1);
                    check("r4_y", a_y, 3);
                end
                138: check("r4_pre_up", a_rv(), 5'b11111);
                139: check("r4_up", a_rv(), 5'b11110);
                default: ;
            endcase
        end

        // Run 5: minimum timing on instance b
        b_reset = 1'b1;
        tick();
        tick();
        b_reset = 1'b0;
        cyc     = 0;
        while (cyc < 9) begin
            b_start = (cyc == 0);
            b_y_in  = 7'd7;
            tick();
            case (cyc)
                1: begin
                    check("b_hold", b_rv(), 5'b11111);
                    check("b_busy", b_busy, 1);
                    check("b_y", b_y, 7);
                end
                2: check("b_up", b_rv(), 5'b11110);
                3: check("b_dn", b_rv(), 5'b11100);
                4: check("b_tok", b_rv(), 5'b11000);
                5: check("b_ds", b_rv(), 5'b10000);
                6: begin
                    check("b_core", b_rv(), 5'b00000);
                    check("b_core_done", b_done, 0);
                end
                7: begin
                    check("b_done", b_done, 1);
                    check("b_done_busy", b_busy, 0);
                end
                8: check("b_sdr", b_sdr, 0);
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
